pmem_responder: RTL and testbench

Line-granular physical-memory responder: the target side of the `pmem_*` request/response handshake that the memory arbiter drives. It accepts one 128-bit line read or write at a time, waits a programmable number of cycles, then returns a single-cycle `pmem_resp` pulse with read data. It is used as the memory model under the cache/arbiter hierarchy and as the template for the eventual DRAM-side controller. It also reports handshake violations and keeps per-operation counters.

---
 rtl/pmem_responder.sv | 150 +++++++++++++++
 tb/tb_pmem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// pmem_responder: line-granular memory target for the pmem_* handshake.
// Accepts one 128-bit line read or write at a time. It responds LATENCY cycles
// after acceptance with a single-cycle pmem_resp pulse. It also flags handshake
// violations and counts completed reads and writes.
//
// Handshake: the requester raises exactly one of pmem_read/pmem_write together
// with pmem_address (and pmem_wdata for writes). It holds them stable until it
// observes pmem_resp=1. The request is accepted on the first rising edge at which
// the responder is ready (IDLE, or the closing edge of TURN). Dropping the
// request, switching the operation or changing the line address before
// pmem_resp sets the sticky proto_err flag. The accepted operation still
// completes as captured.
//
// dbg_state exposes the FSM state (0 IDLE, 1 BUSY, 2 RESP, 3 TURN).
module pmem_responder #(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy,
    output logic         proto_err,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count,
    output logic [1:0]   dbg_state
);

    localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t         state;
    logic           op_write;
    logic [11:0]    line_q;
    logic [127:0]   wdata_q;
    logic [7:0]     cnt;

    // Line storage. It is deliberately outside the reset domain so that reset
    // leaves the contents intact.
    logic [127:0]   mem [DEPTH_LINES];

    logic           req_one;
    logic           req_both;
    logic [11:0]    req_line;
    logic           busy_viol;
    logic           commit;
    logic [IDX_W-1:0] idx_q;
    logic           unused_addr_bits;

    assign req_one   = pmem_read ^ pmem_write;
    assign req_both  = pmem_read & pmem_write;
    assign req_line  = pmem_address[15:4];
    assign idx_q     = line_q[IDX_W-1:0];
    assign commit    = (state == S_BUSY) && (cnt == 8'd0);
    assign dbg_state = state;
    assign unused_addr_bits = ^pmem_address[3:0];

    // While BUSY the requester must keep the captured op asserted, must not
    // assert the other op, and must keep the same line address.
    assign busy_viol = (op_write ? (!pmem_write || pmem_read)
                                 : (!pmem_read  || pmem_write))
                       || (req_line != line_q);

    // Control FSM with registered outputs. The closing edge of TURN may accept a
    // new request, so a request that is still held during RESP is not taken
    // again until one full cycle after the pulse. Back-to-back operations
    // therefore run at one per LATENCY+2 cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_write    <= 1'b0;
            line_q      <= 12'd0;
            wdata_q     <= 128'd0;
            cnt         <= 8'd0;
            pmem_resp   <= 1'b0;
            pmem_rdata  <= 128'd0;
            busy        <= 1'b0;
            proto_err   <= 1'b0;
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_TURN: begin
                    if (req_one) begin
                        op_write <= pmem_write;
                        line_q   <= req_line;
                        wdata_q  <= pmem_wdata;
                        cnt      <= CNT_LOAD;
                        state    <= S_BUSY;
                        busy     <= 1'b1;
                    end else begin
                        if (req_both) begin
                            proto_err <= 1'b1;
                        end
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (busy_viol) begin
                        proto_err <= 1'b1;
                    end
                    if (cnt == 8'd0) begin
                        state     <= S_RESP;
                        pmem_resp <= 1'b1;
                        if (!op_write) begin
                            pmem_rdata <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    pmem_resp <= 1'b0;
                    if (op_write) begin
                        write_count <= write_count + 16'd1;
                    end else begin
                        read_count <= read_count + 16'd1;
                    end
                    state <= S_TURN;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write commit happens on the same edge on which pmem_resp rises. Reset
    // forces the FSM out of BUSY, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (commit && op_write) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder. Three instances are built with different
// LATENCY/DEPTH_LINES, and one shared request bus is steered to the selected one.
module tb_pmem_responder;

    localparam int NDUT = 3;
    int lat_of[NDUT]   = '{10, 3, 1};
    int depth_of[NDUT] = '{4096, 256, 16};

    localparam logic [127:0] DA = {16{8'hA5}};
    localparam logic [127:0] DB = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DC = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] DD = {8{16'h5AC3}};
    localparam logic [127:0] DE = 128'h1;
    localparam logic [127:0] DF = {128{1'b1}};

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // shared request bus and per-instance outputs
    int           sel = 0;
    logic         rd = 1'b0, wr = 1'b0;
    logic [15:0]  addr = 16'd0;
    logic [127:0] wdata = 128'd0;

    logic [NDUT-1:0] rd_v, wr_v, resp_v, busy_v, perr_v;
    logic [127:0]    rdata_v [NDUT];
    logic [15:0]     rc_v [NDUT];
    logic [15:0]     wc_v [NDUT];
    logic [1:0]      st_v [NDUT];

    logic         cur_resp, cur_busy, cur_perr;
    logic [127:0] cur_rdata;
    logic [15:0]  cur_rc, cur_wc;
    logic [1:0]   cur_st;

    for (genvar g = 0; g < NDUT; g++) begin : g_gate
        assign rd_v[g] = rd && (sel == g);
        assign wr_v[g] = wr && (sel == g);
    end

    always_comb begin
        cur_resp  = resp_v[sel];
        cur_busy  = busy_v[sel];
        cur_perr  = perr_v[sel];
        cur_rdata = rdata_v[sel];
        cur_rc    = rc_v[sel];
        cur_wc    = wc_v[sel];
        cur_st    = st_v[sel];
    end

    pmem_responder #(.LATENCY(10), .DEPTH_LINES(4096)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd_v[0]), .pmem_write(wr_v[0]),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(resp_v[0]),
        .pmem_rdata(rdata_v[0]), .busy(busy_v[0]), .proto_err(perr_v[0]),
        .read_count(rc_v[0]), .write_count(wc_v[0]), .dbg_state(st_v[0]));

    pmem_responder #(.LATENCY(3), .DEPTH_LINES(256)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd_v[1]), .pmem_write(wr_v[1]),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(resp_v[1]),
        .pmem_rdata(rdata_v[1]), .busy(busy_v[1]), .proto_err(perr_v[1]),
        .read_count(rc_v[1]), .write_count(wc_v[1]), .dbg_state(st_v[1]));

    pmem_responder #(.LATENCY(1), .DEPTH_LINES(16)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd_v[2]), .pmem_write(wr_v[2]),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(resp_v[2]),
        .pmem_rdata(rdata_v[2]), .busy(busy_v[2]), .proto_err(perr_v[2]),
        .read_count(rc_v[2]), .write_count(wc_v[2]), .dbg_state(st_v[2]));

    // scoreboard and reference model
    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];
    logic [127:0] ref_mem [int];
    int           exp_rc[NDUT];
    int           exp_wc[NDUT];
    logic [127:0] last_rd[NDUT];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int mkey(input int s, input logic [15:0] a);
        return s * 65536 + (int'(a[15:4]) % depth_of[s]);
    endfunction

    // Returns the pmem_rdata value expected at the response. Reads return the
    // stored line, and writes leave the previous read data in place.
    task automatic model_op(input int s, input bit is_wr, input logic [15:0] a,
                            input logic [127:0] d, output logic [127:0] exp_rd);
        int k;
        k = mkey(s, a);
        if (is_wr) begin
            ref_mem[k] = d;
            exp_wc[s]++;
            exp_rd = last_rd[s];
        end else begin
            exp_rd = ref_mem.exists(k) ? ref_mem[k] : 128'd0;
            last_rd[s] = exp_rd;
            exp_rc[s]++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int s = 0; s < NDUT; s++) begin
            exp_rc[s] = 0; exp_wc[s] = 0; last_rd[s] = 128'd0;
        end
    endtask

    task automatic check_counts(input string tag);
        for (int s = 0; s < NDUT; s++) begin
            sel = s; #1;
            check($sformatf("%s_rc%0d", tag, s), cur_rc, 16'(exp_rc[s]));
            check($sformatf("%s_wc%0d", tag, s), cur_wc, 16'(exp_wc[s]));
        end
    endtask

    // Driver: issue one op and hold it until resp. Optionally change the address
    // after change_at cycles. Returns the acceptance-to-resp latency in cycles.
    task automatic do_op(input int s, input bit is_wr, input logic [15:0] a,
                         input logic [127:0] d, input int change_at,
                         input logic [15:0] a2, output int lat,
                         output logic [127:0] rd_seen);
        int  n;
        bit  got;
        sel = s;
        @(posedge clk); #1;
        rd = !is_wr; wr = is_wr; addr = a; wdata = d;
        n = 0; got = 0; lat = -1; rd_seen = 128'd0;
        while (!got && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("busy_after_accept", cur_busy, 1'b1);
            if (cur_resp) begin
                got = 1; lat = n - 1; rd_seen = cur_rdata;
            end else if (n == change_at) begin
                addr = a2;
            end
        end
        rd = 1'b0; wr = 1'b0;
        if (!got) check("resp_timeout", 1'b0, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        check("idle_after_op", cur_busy, 1'b0);
    endtask

    typedef struct {
        int           s;
        bit           is_wr;
        logic [15:0]  a;
        logic [127:0] d;
        logic [127:0] exp_rd;
        int           exp_lat;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int           lat;
        logic [127:0] got_rd, mexp;
        int           pulses, last_n;
        bit           saw_busy, saw_resp;

        tbl[0]  = '{0, 1'b1, 16'h1230, DA,     128'd0, 10};
        tbl[1]  = '{0, 1'b0, 16'h1238, 128'd0, DA,     10};
        tbl[2]  = '{0, 1'b1, 16'h0FF0, DB,     DA,     10};
        tbl[3]  = '{0, 1'b1, 16'hFFF0, DC,     DA,     10};
        tbl[4]  = '{0, 1'b0, 16'h0FF0, 128'd0, DB,     10};
        tbl[5]  = '{0, 1'b1, 16'h1230, DD,     DB,     10};
        tbl[6]  = '{0, 1'b0, 16'h123C, 128'd0, DD,     10};
        tbl[7]  = '{1, 1'b1, 16'hFFF0, DC,     128'd0, 3};
        tbl[8]  = '{1, 1'b0, 16'h0FF0, 128'd0, DC,     3};
        tbl[9]  = '{1, 1'b0, 16'h5FF4, 128'd0, DC,     3};
        tbl[10] = '{1, 1'b1, 16'h0FF0, DF,     DC,     3};
        tbl[11] = '{1, 1'b0, 16'hFFF8, 128'd0, DF,     3};
        tbl[12] = '{2, 1'b1, 16'h0010, DE,     128'd0, 1};
        tbl[13] = '{2, 1'b1, 16'h0110, DB,     128'd0, 1};
        tbl[14] = '{2, 1'b0, 16'h001F, 128'd0, DB,     1};
        tbl[15] = '{2, 1'b1, 16'h0020, DA,     DB,     1};
        tbl[16] = '{2, 1'b0, 16'h0020, 128'd0, DA,     1};

        // reset state
        for (int s = 0; s < NDUT; s++) begin
            exp_rc[s] = 0; exp_wc[s] = 0; last_rd[s] = 128'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < NDUT; s++) begin
            sel = s; #1;
            check($sformatf("rst_resp%0d", s), cur_resp, 1'b0);
            check($sformatf("rst_rdata%0d", s), cur_rdata, 128'd0);
            check($sformatf("rst_busy%0d", s), cur_busy, 1'b0);
            check($sformatf("rst_perr%0d", s), cur_perr, 1'b0);
            check($sformatf("rst_rc%0d", s), cur_rc, 16'd0);
            check($sformatf("rst_wc%0d", s), cur_wc, 16'd0);
            check($sformatf("rst_state%0d", s), cur_st, 2'd0);
        end

        // table-driven vectors
        for (int i = 0; i < 17; i++) begin
            model_op(tbl[i].s, tbl[i].is_wr, tbl[i].a, tbl[i].d, mexp);
            do_op(tbl[i].s, tbl[i].is_wr, tbl[i].a, tbl[i].d, 0, 16'd0, lat, got_rd);
            check($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
            check($sformatf("v%0d_rdata", i), got_rd, tbl[i].exp_rd);
        end
        check_counts("tbl");

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            int           s;
            bit           w;
            logic [15:0]  a;
            logic [127:0] d;
            s = $urandom_range(0, NDUT - 1);
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 65535)) & 16'hC07F;
            d = {$urandom, $urandom, $urandom, $urandom};
            model_op(s, w, a, d, mexp);
            exp_q.push_back(mexp);
            do_op(s, w, a, d, 0, 16'd0, lat, got_rd);
            check($sformatf("rnd%0d_lat", i), lat, lat_of[s]);
            check($sformatf("rnd%0d_rdata", i), got_rd, exp_q.pop_front());
        end
        check_counts("rnd");
        for (int s = 0; s < NDUT; s++) begin
            sel = s; #1;
            check($sformatf("rnd_perr%0d", s), cur_perr, 1'b0);
        end

        // held read, LATENCY=3: one accept every LATENCY+2 cycles
        sel = 1;
        begin
            int k;
            k = mkey(1, 16'h0FF0);
            mexp = ref_mem.exists(k) ? ref_mem[k] : 128'd0;
        end
        @(posedge clk); #1;
        rd = 1'b1; addr = 16'h0FF0;
        pulses = 0; last_n = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (cur_resp) begin
                pulses++;
                check($sformatf("hold_rdata%0d", pulses), cur_rdata, mexp);
                if (pulses > 1) check($sformatf("hold_gap%0d", pulses), n - last_n, lat_of[1] + 2);
                last_n = n;
            end
        end
        rd = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (cur_resp) pulses++;
        end
        check("hold_pulses", pulses, 6);
        check("hold_perr", cur_perr, 1'b0);
        check("hold_busy_end", cur_busy, 1'b0);
        exp_rc[1] += 6;
        last_rd[1] = mexp;
        check_counts("hold");

        // both requests in IDLE: rejected, sticky proto_err
        sel = 0;
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b1; addr = 16'h0200; wdata = DC;
        saw_busy = 0; saw_resp = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            saw_busy |= cur_busy;
            saw_resp |= cur_resp;
        end
        rd = 1'b0; wr = 1'b0;
        check("both_no_busy", saw_busy, 1'b0);
        check("both_no_resp", saw_resp, 1'b0);
        check("both_perr", cur_perr, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("both_perr_sticky", cur_perr, 1'b1);
        model_op(0, 1'b0, 16'h1230, 128'd0, mexp);
        do_op(0, 1'b0, 16'h1230, 128'd0, 0, 16'd0, lat, got_rd);
        check("both_after_rdata", got_rd, mexp);
        check("both_after_perr", cur_perr, 1'b1);
        do_reset();
        sel = 0; #1;
        check("both_perr_cleared", cur_perr, 1'b0);

        // address change mid-BUSY: captured line still returned
        model_op(0, 1'b1, 16'h0050, DC, mexp);
        do_op(0, 1'b1, 16'h0050, DC, 0, 16'd0, lat, got_rd);
        model_op(0, 1'b1, 16'h0040, DB, mexp);
        do_op(0, 1'b1, 16'h0040, DB, 0, 16'd0, lat, got_rd);
        check("chg_pre_perr", cur_perr, 1'b0);
        model_op(0, 1'b0, 16'h0040, 128'd0, mexp);
        do_op(0, 1'b0, 16'h0040, 128'd0, 4, 16'h0050, lat, got_rd);
        check("chg_lat", lat, 10);
        check("chg_rdata", got_rd, DB);
        check("chg_perr", cur_perr, 1'b1);

        // reset in BUSY of a write: aborted, old contents kept
        do_reset();
        model_op(0, 1'b1, 16'h0100, DE, mexp);
        do_op(0, 1'b1, 16'h0100, DE, 0, 16'd0, lat, got_rd);
        model_op(0, 1'b0, 16'h0040, 128'd0, mexp);
        do_op(0, 1'b0, 16'h0040, 128'd0, 0, 16'd0, lat, got_rd);
        sel = 0;
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        check("abort_pre_perr", cur_perr, 1'b1);
        @(posedge clk); #1;
        wr = 1'b1; addr = 16'h0100; wdata = DF;
        repeat (5) @(posedge clk);
        #1 check("abort_pre_busy", cur_busy, 1'b1);
        check("abort_pre_rdata", cur_rdata, DB);
        #3 reset_n = 1'b0;
        #1;
        check("abort_resp", cur_resp, 1'b0);
        check("abort_rdata", cur_rdata, 128'd0);
        check("abort_busy", cur_busy, 1'b0);
        check("abort_perr", cur_perr, 1'b0);
        check("abort_rc", cur_rc, 16'd0);
        check("abort_wc", cur_wc, 16'd0);
        wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int s = 0; s < NDUT; s++) begin
            exp_rc[s] = 0; exp_wc[s] = 0; last_rd[s] = 128'd0;
        end
        saw_resp = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            saw_resp |= cur_resp;
        end
        check("abort_no_resp", saw_resp, 1'b0);
        model_op(0, 1'b0, 16'h0100, 128'd0, mexp);
        do_op(0, 1'b0, 16'h0100, 128'd0, 0, 16'd0, lat, got_rd);
        check("abort_old_data", got_rd, DE);
        check("abort_model_data", got_rd, mexp);
        check_counts("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
